// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: opcodes, FSM states,
// instruction classes and ALU operation selects.
package legv8_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;
  localparam logic [5:0]  OP_B_HI   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    BRANCH,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LD,
    CLS_ST,
    CLS_CBZ,
    CLS_B,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: maps IR[31:21] onto the controller's
// instruction classes; anything unrecognised is ILLEGAL.
module instr_class_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  cls
);

  instr_class_t c;

  always_comb begin
    c = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      c = CLS_R;
    else if (opcode == OP_LDUR)
      c = CLS_LD;
    else if (opcode == OP_STUR)
      c = CLS_ST;
    else if (opcode[10:3] == OP_CBZ_HI)
      c = CLS_CBZ;
    else if (opcode[10:5] == OP_B_HI)
      c = CLS_B;
  end

  assign cls = c;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle LEGv8 sequencer sharing one memory port between fetch and data
// access, with a retire counter and sticky halt on illegal opcode or timeout.
module multicycle_controller
  import legv8_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [10:0]      opcode,
  input  logic             aluZero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iorD,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic             reg2loc,
  output logic             aluSrc,
  output logic [1:0]       aluOp,
  output logic             regWrite,
  output logic             mem2reg,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  state_t       state, next_state;
  instr_class_t cls_q, dec_cls;
  logic [2:0]   dec_cls_raw;
  logic [31:0]  wait_cnt;
  logic         err_q;
  logic [CNT_W-1:0] cnt_q;
  logic         waiting, timeout_hit, retire;

  instr_class_decode u_decode (
    .opcode (opcode),
    .cls    (dec_cls_raw)
  );

  assign dec_cls = instr_class_t'(dec_cls_raw);

  // Waiting is derived from state rather than mem_req to keep the output
  // decode free of a combinational loop through the timeout check.
  assign waiting     = (state == FETCH || state == MEM) && !mem_ack;
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == MEM_TIMEOUT - 32'd1);
  assign retire      = (state == WB) || (state == BRANCH) ||
                       (state == MEM && cls_q == CLS_ST && mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_IDLE;
      cls_q    <= CLS_ILLEGAL;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE)
        cls_q <= dec_cls;
      if (next_state != state || !waiting)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 32'd1;
      if (state != HALT && next_state == HALT)
        err_q <= timeout_hit;
      if (retire)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iorD       = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    reg2loc    = 1'b0;
    aluSrc     = 1'b0;
    aluOp      = ALUOP_ADD;
    regWrite   = 1'b0;
    mem2reg    = 1'b0;
    halted     = 1'b0;
    error      = 1'b0;
    unique case (state)
      FETCH_IDLE: begin
        if (run)
          next_state = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          next_state = DECODE;
        end else if (timeout_hit) begin
          next_state = HALT;
        end
      end
      DECODE: begin
        reg2loc = (dec_cls == CLS_ST) || (dec_cls == CLS_CBZ);
        unique case (dec_cls)
          CLS_R, CLS_LD, CLS_ST: next_state = EXEC;
          CLS_CBZ, CLS_B:        next_state = BRANCH;
          default:               next_state = HALT;
        endcase
      end
      EXEC: begin
        reg2loc = (cls_q == CLS_ST);
        if (cls_q == CLS_R) begin
          aluOp      = ALUOP_FUNCT;
          next_state = WB;
        end else begin
          aluSrc     = 1'b1;
          aluOp      = ALUOP_ADD;
          next_state = MEM;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        iorD    = 1'b1;
        mem_we  = (cls_q == CLS_ST);
        reg2loc = (cls_q == CLS_ST);
        if (mem_ack)
          next_state = (cls_q == CLS_LD) ? WB : FETCH_IDLE;
        else if (timeout_hit)
          next_state = HALT;
      end
      WB: begin
        regWrite   = 1'b1;
        mem2reg    = (cls_q == CLS_LD);
        next_state = FETCH_IDLE;
      end
      BRANCH: begin
        aluOp      = ALUOP_PASSB;
        reg2loc    = 1'b1;
        pcSrc      = 1'b1;
        pcWrite    = (cls_q == CLS_B) || (cls_q == CLS_CBZ && aluZero);
        next_state = FETCH_IDLE;
      end
      HALT: begin
        halted = 1'b1;
        error  = err_q;
      end
      default: next_state = FETCH_IDLE;
    endcase
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: a per-instruction schedule model
// predicts every cycle's control vector, the retire count and halt behaviour.
module tb_multicycle_controller;

  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, run, aluZero, mem_ack;
  logic [10:0]   opcode;
  logic          mem_req, mem_we, iorD, irWrite, pcWrite, pcSrc, reg2loc, aluSrc;
  logic [1:0]    aluOp;
  logic          regWrite, mem2reg, halted, error;
  logic [CW-1:0] instr_count;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .aluZero(aluZero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iorD(iorD),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .reg2loc(reg2loc),
    .aluSrc(aluSrc), .aluOp(aluOp), .regWrite(regWrite), .mem2reg(mem2reg),
    .halted(halted), .error(error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [13:0] REQ  = 14'h2000, WE   = 14'h1000, IORD = 14'h0800,
                          IRW  = 14'h0400, PCW  = 14'h0200, PCS  = 14'h0100,
                          R2L  = 14'h0080, ASRC = 14'h0040, AOPF = 14'h0020,
                          AOPP = 14'h0010, RW   = 14'h0008, M2R  = 14'h0004,
                          HLT  = 14'h0002, ERR  = 14'h0001;

  typedef enum {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned exp_cnt = 0;
  logic [13:0] outs;
  logic [10:0] rops [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};

  assign outs = {mem_req, mem_we, iorD, irWrite, pcWrite, pcSrc, reg2loc, aluSrc,
                 aluOp, regWrite, mem2reg, halted, error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [10:0] op);
    if (op == rops[0] || op == rops[1] || op == rops[2] || op == rops[3]) return K_R;
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  // Called at a falling edge with inputs already driven; advances one cycle.
  task automatic step(input string tag, input logic [13:0] exp);
    #1;
    check(tag, 32'(outs), 32'(exp));
    @(negedge clk);
  endtask

  task automatic noise();
    mem_ack = 1'($urandom);
    run     = 1'($urandom);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_count", 32'(instr_count), 32'd0);
    run     = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic retire_one();
    exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  task automatic access(input string tag, input int waits, input logic [13:0] v,
                        input logic [13:0] extra, input bit abort, output bit ended);
    ended = 1'b0;
    if (waits >= TO) begin
      mem_ack = 1'b0;
      repeat (TO) step(tag, v);
      step("timeout_halt", HLT | ERR);
      repeat (2) begin
        noise();
        step("timeout_hold", HLT | ERR);
      end
      reset_dut();
      ended = 1'b1;
      return;
    end
    for (int i = 0; i < waits; i++) begin
      if (abort && i == 1) begin
        reset_dut();
        ended = 1'b1;
        return;
      end
      mem_ack = 1'b0;
      step(tag, v);
    end
    mem_ack = 1'b1;
    step(tag, v | extra);
  endtask

  task automatic do_instr(input logic [10:0] op, input int wf, input int wm,
                          input bit z, input bit abort);
    kind_t k;
    bit    ended;
    k = classify(op);
    run = 1'b0;
    mem_ack = 1'($urandom);
    check("count", 32'(instr_count), exp_cnt);
    repeat ($urandom_range(0, 2)) step("idle_norun", 14'h0);
    run = 1'b1;
    step("idle", 14'h0);
    access("fetch", wf, REQ, IRW | PCW, 1'b0, ended);
    if (ended) return;
    noise();
    aluZero = 1'($urandom);
    opcode  = op;
    step("decode", (k == K_ST || k == K_CBZ) ? R2L : 14'h0);
    opcode = 11'($urandom);
    noise();
    case (k)
      K_ILL: begin
        step("halt_illegal", HLT);
        repeat (2) begin
          noise();
          step("halt_hold", HLT);
        end
        reset_dut();
      end
      K_R: begin
        step("exec_r", AOPF);
        noise();
        step("wb_r", RW);
        retire_one();
      end
      K_LD: begin
        step("exec_ld", ASRC);
        access("mem_ld", wm, REQ | IORD, 14'h0, abort, ended);
        if (ended) return;
        noise();
        step("wb_ld", RW | M2R);
        retire_one();
      end
      K_ST: begin
        step("exec_st", ASRC | R2L);
        access("mem_st", wm, REQ | IORD | WE | R2L, 14'h0, abort, ended);
        if (ended) return;
        retire_one();
      end
      default: begin
        aluZero = z;
        step("branch", AOPP | R2L | PCS | ((k == K_B || z) ? PCW : 14'h0));
        retire_one();
      end
    endcase
  endtask

  function automatic logic [10:0] rand_op();
    int unsigned sel;
    logic [10:0] op;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3: op = rops[sel];
      4:          op = 11'b11111000010;
      5:          op = 11'b11111000000;
      6:          op = {8'b10110100, 3'($urandom)};
      7:          op = {6'b000101, 5'($urandom)};
      8:          op = 11'($urandom);
      default:    op = rops[$urandom_range(0, 3)];
    endcase
    return op;
  endfunction

  initial begin
    rst_n   = 1'b0;
    run     = 1'b0;
    mem_ack = 1'b0;
    opcode  = '0;
    aluZero = 1'b0;
    @(negedge clk);
    #1;
    check("por_outs", 32'(outs), 32'd0);
    check("por_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_instr(11'b10001011000, 1, 0, 1'b0, 1'b0);
    do_instr(11'b11111000010, 1, 3, 1'b0, 1'b0);
    do_instr(11'b11111000000, 1, 1, 1'b0, 1'b0);
    do_instr(11'b10110100000, 0, 0, 1'b0, 1'b0);
    do_instr(11'b10110100101, 0, 0, 1'b1, 1'b0);
    do_instr(11'b00010100000, 0, 0, 1'b0, 1'b0);
    do_instr(11'b11001011000, 0, 0, 1'b0, 1'b0);
    do_instr(11'b10001010000, 2, 0, 1'b0, 1'b0);
    do_instr(11'b10101010000, 0, 0, 1'b0, 1'b0);
    do_instr(11'b11111000010, TO - 1, TO - 1, 1'b0, 1'b0);
    do_instr(11'b11111111111, 0, 0, 1'b0, 1'b0);
    do_instr(11'b10001011000, TO, 0, 1'b0, 1'b0);
    do_instr(11'b11111000010, 0, TO, 1'b0, 1'b0);
    do_instr(11'b11111000010, 0, 5, 1'b0, 1'b1);
    for (int n = 0; n < 17; n++)
      do_instr({6'b000101, 5'($urandom)}, 0, 0, 1'b0, 1'b0);
    do_instr(11'b11001011000, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++)
      do_instr(rand_op(), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               1'($urandom), 1'b0);
    run = 1'b0;
    check("final_count", 32'(instr_count), exp_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
